// File: rtl/tile_renderer_if.sv
// Pixel-stream and tile-map write bundle between the VGA sync stage / game logic and tile_renderer.
// No valid/ready handshake: the pixel stream advances every clock and WrEn is a single-cycle strobe.
interface tile_renderer_if;
  logic       HSYNC_in;
  logic       VSYNC_in;
  logic [9:0] X;
  logic [8:0] Y;
  logic       WrEn;
  logic [9:0] WrAddr;
  logic [3:0] WrData;
  logic [5:0] CursorCol;
  logic [4:0] CursorRow;
  logic       CursorEn;
  logic       HSYNC;
  logic       VSYNC;
  logic [2:0] Red;
  logic [2:0] Green;
  logic [1:0] Blue;

  modport master (
    output HSYNC_in, VSYNC_in, X, Y, WrEn, WrAddr, WrData, CursorCol, CursorRow, CursorEn,
    input  HSYNC, VSYNC, Red, Green, Blue
  );

  modport slave (
    input  HSYNC_in, VSYNC_in, X, Y, WrEn, WrAddr, WrData, CursorCol, CursorRow, CursorEn,
    output HSYNC, VSYNC, Red, Green, Blue
  );
endinterface

// File: rtl/tile_renderer.sv
// 40x25 tile-map renderer: 3-stage pipeline turning (X, Y, syncs) into 3-3-2 RGB with
// matched sync delay and a blinking cursor outline.
module tile_renderer #(
  parameter int TilesX        = 40,
  parameter int TilesY        = 25,
  parameter int VisiblePixels = 640,
  parameter int VisibleRows   = 400
) (
  input  logic            Pixelclock,
  input  logic            Reset,
  tile_renderer_if.slave  bus
);
  localparam int         Depth    = TilesX * TilesY;
  localparam logic [9:0] LP_DEPTH = 10'(Depth);
  localparam logic [10:0] LP_ADDR_LIM = 11'(Depth);
  localparam logic [9:0] LP_VIS_X = 10'(VisiblePixels);
  localparam logic [8:0] LP_VIS_Y = 9'(VisibleRows);

  logic [3:0] r_mem [Depth];

  logic [5:0]  w_col;
  logic [4:0]  w_row;
  logic [10:0] w_addr;
  logic        w_vis;
  logic        w_edge;
  logic        w_hit;
  logic        w_frame_tick;
  logic [9:0]  w_rd_addr;
  logic        w_blink;

  logic [10:0] r_s1_addr;
  logic        r_s1_vis, r_s1_hit, r_s1_hs, r_s1_vs;
  logic [3:0]  r_s2_idx;
  logic        r_s2_vis, r_s2_hit, r_s2_hs, r_s2_vs;
  logic        r_hs, r_vs;
  logic [2:0]  r_red, r_green;
  logic [1:0]  r_blue;
  logic [5:0]  r_frame_cnt;

  assign w_col        = bus.X[9:4];
  assign w_row        = bus.Y[8:4];
  // row*40 + col as two shifts and an add
  assign w_addr       = 11'({w_row, 5'b0}) + 11'({w_row, 3'b0}) + 11'(w_col);
  assign w_vis        = (bus.X < LP_VIS_X) && (bus.Y < LP_VIS_Y);
  assign w_edge       = (bus.X[3:0] == 4'd0) || (bus.X[3:0] == 4'd15) ||
                        (bus.Y[3:0] == 4'd0) || (bus.Y[3:0] == 4'd15);
  assign w_hit        = bus.CursorEn && (w_col == bus.CursorCol) &&
                        (w_row == bus.CursorRow) && w_edge;
  assign w_frame_tick = (bus.X == 10'd0) && (bus.Y == 9'd0);
  // Blank pixels can form addresses past the map; keep the read in range
  assign w_rd_addr    = (r_s1_addr < LP_ADDR_LIM) ? r_s1_addr[9:0] : 10'd0;
  assign w_blink      = r_frame_cnt[5];

  always_ff @(posedge Pixelclock) begin
    if (bus.WrEn && (bus.WrAddr < LP_DEPTH)) begin
      r_mem[bus.WrAddr] <= bus.WrData;
    end
  end

  always_ff @(posedge Pixelclock or posedge Reset) begin
    if (Reset) begin
      r_s1_addr   <= '0;
      r_s1_vis    <= 1'b0;
      r_s1_hit    <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s2_idx    <= '0;
      r_s2_vis    <= 1'b0;
      r_s2_hit    <= 1'b0;
      r_s2_hs     <= 1'b0;
      r_s2_vs     <= 1'b0;
      r_hs        <= 1'b0;
      r_vs        <= 1'b0;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_s1_addr <= w_addr;
      r_s1_vis  <= w_vis;
      r_s1_hit  <= w_hit;
      r_s1_hs   <= bus.HSYNC_in;
      r_s1_vs   <= bus.VSYNC_in;
      if (w_frame_tick) begin
        r_frame_cnt <= r_frame_cnt + 6'd1;
      end

      // read-first: a same-edge write is not seen by this read
      r_s2_idx <= r_mem[w_rd_addr];
      r_s2_vis <= r_s1_vis;
      r_s2_hit <= r_s1_hit;
      r_s2_hs  <= r_s1_hs;
      r_s2_vs  <= r_s1_vs;

      r_hs <= r_s2_hs;
      r_vs <= r_s2_vs;
      if (!r_s2_vis) begin
        r_red   <= 3'b000;
        r_green <= 3'b000;
        r_blue  <= 2'b00;
      end else if (r_s2_hit && w_blink) begin
        r_red   <= 3'b111;
        r_green <= 3'b111;
        r_blue  <= 2'b11;
      end else begin
        r_red   <= {r_s2_idx[2], r_s2_idx[2], r_s2_idx[3]};
        r_green <= {r_s2_idx[1], r_s2_idx[1], r_s2_idx[3]};
        r_blue  <= {r_s2_idx[0], r_s2_idx[3]};
      end
    end
  end

  assign bus.HSYNC = r_hs;
  assign bus.VSYNC = r_vs;
  assign bus.Red   = r_red;
  assign bus.Green = r_green;
  assign bus.Blue  = r_blue;
endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: vectors carry hand-computed {HSYNC,VSYNC,RGB} expectations,
// checked three cycles after they are driven.
module tb_tile_renderer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  tile_renderer_if bus();

  tile_renderer dut (
    .Pixelclock (clk),
    .Reset      (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [9:0] exp_q[$];
  logic [5:0] tb_frame = 6'd0;
  logic       cur_en = 1'b0;

  int         vx[$];
  int         vy[$];
  logic       vh[$];
  logic       vv[$];
  logic       vc[$];
  logic       vw[$];
  int         va[$];
  logic [3:0] vd[$];
  logic [7:0] ve[$];

  function automatic logic [9:0] obs();
    return {bus.HSYNC, bus.VSYNC, bus.Red, bus.Green, bus.Blue};
  endfunction

  task automatic clear_vecs();
    vx.delete(); vy.delete(); vh.delete(); vv.delete(); vc.delete();
    vw.delete(); va.delete(); vd.delete(); ve.delete(); exp_q.delete();
  endtask

  task automatic add_pix(input int x, input int y, input logic hs, input logic vs, input logic [7:0] rgb);
    vx.push_back(x); vy.push_back(y); vh.push_back(hs); vv.push_back(vs); vc.push_back(cur_en);
    vw.push_back(1'b0); va.push_back(0); vd.push_back(4'd0); ve.push_back(rgb);
  endtask

  task automatic add_wr(input int x, input int y, input logic [7:0] rgb, input int wa, input logic [3:0] wd);
    add_pix(x, y, 1'b0, 1'b0, rgb);
    vw[vw.size()-1] = 1'b1;
    va[va.size()-1] = wa;
    vd[vd.size()-1] = wd;
  endtask

  task automatic drive_vec(input int i);
    bus.X = 10'(vx[i]); bus.Y = 9'(vy[i]);
    bus.HSYNC_in = vh[i]; bus.VSYNC_in = vv[i]; bus.CursorEn = vc[i];
    bus.WrEn = vw[i]; bus.WrAddr = 10'(va[i]); bus.WrData = vd[i];
    if (!rst && vx[i] == 0 && vy[i] == 0) tb_frame = tb_frame + 6'd1;
    exp_q.push_back({vh[i], vv[i], ve[i]});
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.X = 10'd700; bus.Y = 9'd450; bus.HSYNC_in = 1'b0; bus.VSYNC_in = 1'b0;
    bus.WrEn = 1'b0; bus.CursorEn = 1'b0;
    exp_q.push_back(10'h0);
    @(negedge clk);
  endtask

  task automatic fill_map(input logic [3:0] d);
    bus.WrEn = 1'b1;
    for (int a = 0; a < 1000; a++) begin
      bus.WrAddr = 10'(a); bus.WrData = d;
      @(negedge clk);
    end
    bus.WrEn = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    for (int k = 0; k < 8; k++) begin
      bus.X = 10'((k * 97) % 1024); bus.Y = 9'((k * 61) % 512);
      bus.HSYNC_in = 1'b1; bus.VSYNC_in = 1'b1;
      @(negedge clk);
      n_checks++;
      if (obs() !== 10'h0) begin
        n_errors++;
        $display("FAIL reset_hold k=%0d got=%h exp=000", k, obs());
      end
    end
    bus.X = 10'd700; bus.Y = 9'd450;
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      e = (k == 3) ? 10'h300 : 10'h000;
      n_checks++;
      if (obs() !== e) begin
        n_errors++;
        $display("FAIL reset_release cycle=%0d got=%h exp=%h", k, obs(), e);
      end
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 10'h0) begin
      n_errors++;
      $display("FAIL reset_async got=%h exp=000", obs());
    end
    @(negedge clk);
    rst = 1'b0;
    tb_frame = 6'd0;
    bus.HSYNC_in = 1'b0; bus.VSYNC_in = 1'b0;
  endtask

  task automatic test_single_tile();
    logic [9:0] e;
    int ys[5] = '{15, 16, 24, 31, 32};
    fill_map(4'd0);
    clear_vecs();
    add_wr(700, 450, 8'h00, 41, 4'b0100);
    for (int j = 0; j < 5; j++)
      for (int x = 12; x < 36; x++)
        add_pix(x, ys[j], x[0], ys[j][0],
                (x >= 16 && x < 32 && ys[j] >= 16 && ys[j] < 32) ? 8'b110_000_00 : 8'h00);
    for (int i = 0; i < vx.size() + 2; i++) begin
      if (i < vx.size()) drive_vec(i); else drive_idle();
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin
          n_errors++;
          $display("FAIL single_tile vec=%0d x=%0d y=%0d got=%h exp=%h", i-2, vx[i-2], vy[i-2], obs(), e);
        end
      end
    end
  endtask

  task automatic test_sync_align();
    logic [9:0] e;
    logic [15:0] hp = 16'b1011001110001011;
    logic [15:0] vp = 16'b0110100111010001;
    clear_vecs();
    for (int i = 0; i < 16; i++)
      add_pix(i[0] ? 20 : 700, 20, hp[i], vp[i], i[0] ? 8'b110_000_00 : 8'h00);
    for (int i = 0; i < vx.size() + 2; i++) begin
      if (i < vx.size()) drive_vec(i); else drive_idle();
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin
          n_errors++;
          $display("FAIL sync_align vec=%0d got=%h exp=%h", i-2, obs(), e);
        end
      end
    end
  endtask

  task automatic test_blanking();
    logic [9:0] e;
    fill_map(4'd15);
    clear_vecs();
    add_pix(639, 0, 1, 0, 8'hFF);   add_pix(640, 0, 0, 1, 8'h00);
    add_pix(639, 399, 1, 1, 8'hFF); add_pix(0, 399, 0, 0, 8'hFF);
    add_pix(0, 400, 1, 0, 8'h00);   add_pix(639, 400, 0, 1, 8'h00);
    add_pix(800, 10, 1, 1, 8'h00);  add_pix(1023, 511, 0, 0, 8'h00);
    add_pix(320, 200, 1, 0, 8'hFF); add_pix(5, 449, 0, 1, 8'h00);
    add_wr(320, 200, 8'hFF, 1000, 4'd0);
    add_pix(639, 399, 1, 0, 8'hFF); add_pix(0, 1, 0, 1, 8'hFF);
    add_pix(8, 8, 1, 1, 8'hFF);     add_pix(320, 200, 0, 0, 8'hFF);
    add_wr(1, 1, 8'hFF, 999, 4'b1001);
    add_pix(639, 399, 1, 0, 8'b001_001_11); add_pix(624, 384, 0, 1, 8'b001_001_11);
    add_pix(623, 384, 1, 1, 8'hFF);         add_pix(639, 383, 0, 0, 8'hFF);
    for (int i = 0; i < vx.size() + 2; i++) begin
      if (i < vx.size()) drive_vec(i); else drive_idle();
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin
          n_errors++;
          $display("FAIL blanking vec=%0d x=%0d y=%0d got=%h exp=%h", i-2, vx[i-2], vy[i-2], obs(), e);
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [9:0] e;
    clear_vecs();
    add_wr(700, 450, 8'h00, 5, 4'b0011);
    add_pix(80, 0, 1, 0, 8'b000_110_10);
    add_pix(80, 0, 0, 1, 8'b000_110_10);
    add_wr(80, 0, 8'b001_111_01, 5, 4'b1010);
    add_pix(81, 1, 1, 1, 8'b001_111_01);
    add_pix(95, 15, 0, 0, 8'b001_111_01);
    for (int i = 0; i < vx.size() + 2; i++) begin
      if (i < vx.size()) drive_vec(i); else drive_idle();
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin
          n_errors++;
          $display("FAIL collision vec=%0d got=%h exp=%h", i-2, obs(), e);
        end
      end
    end
  endtask

  task automatic test_cursor_blink();
    logic [9:0] e;
    logic [5:0] fr;
    logic [7:0] w;
    fill_map(4'd0);
    bus.CursorCol = 6'd39; bus.CursorRow = 5'd24;
    clear_vecs();
    fr = tb_frame;
    for (int f = 0; f < 64; f++) begin
      w = fr[5] ? 8'hFF : 8'h00;
      if (fr == 6'd40) begin
        cur_en = 1'b0;
        add_pix(624, 384, 1, 0, 8'h00);
      end
      cur_en = 1'b1;
      add_pix(624, 384, 0, 1, w);
      add_pix(639, 390, 1, 0, w);
      add_pix(630, 399, 0, 0, w);
      add_pix(631, 384, 1, 1, w);
      add_pix(630, 390, 0, 1, 8'h00);
      add_pix(623, 384, 1, 0, 8'h00);
      add_pix(0, 0, 0, 0, 8'h00);
      fr = fr + 6'd1;
    end
    cur_en = 1'b0;
    for (int i = 0; i < vx.size() + 2; i++) begin
      if (i < vx.size()) drive_vec(i); else drive_idle();
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin
          n_errors++;
          $display("FAIL cursor_blink vec=%0d x=%0d y=%0d got=%h exp=%h", i-2, vx[i-2], vy[i-2], obs(), e);
        end
      end
    end
  endtask

  initial begin
    bus.X = 10'd700; bus.Y = 9'd450; bus.HSYNC_in = 1'b0; bus.VSYNC_in = 1'b0;
    bus.WrEn = 1'b0; bus.WrAddr = 10'd0; bus.WrData = 4'd0;
    bus.CursorCol = 6'd0; bus.CursorRow = 5'd0; bus.CursorEn = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_tile();
    test_sync_align();
    test_blanking();
    test_collision();
    test_cursor_blink();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tile_renderer.md
# tile_renderer

Consumes the pixel coordinates and sync pulses produced by the VGA sync stage and generates 8-bit RGB (3-3-2) for a 640x400 display. The screen is a 40x25 map of 16x16-pixel tiles. Each tile holds a 4-bit colour index, written by game logic through a single write port. Output RGB and the sync pulses are delayed through a matched 3-stage pipeline, so they leave the block aligned.

## Interface
Parameters:
- TilesX, 40, tiles per row (640/16)
- TilesY, 25, tile rows (400/16)
- VisiblePixels, 640, visible X range is 0..VisiblePixels-1
- VisibleRows, 400, visible Y range is 0..VisibleRows-1

Ports:
- Pixelclock  in  1  pixel clock; the only clock
- Reset  in  1  asynchronous, active-high reset
- HSYNC_in  in  1  horizontal sync from the sync stage, polarity passed through untouched
- VSYNC_in  in  1  vertical sync from the sync stage, polarity passed through untouched
- X  in  10  current pixel column
- Y  in  9  current pixel row
- WrEn  in  1  tile-map write strobe
- WrAddr  in  10  tile index = row*40 + col, range 0..999
- WrData  in  4  colour index to store
- CursorCol  in  6  cursor tile column, 0..39
- CursorRow  in  5  cursor tile row, 0..24
- CursorEn  in  1  enables the cursor overlay
- HSYNC  out  1  HSYNC_in delayed 3 cycles
- VSYNC  out  1  VSYNC_in delayed 3 cycles
- Red  out  3  red component
- Green  out  3  green component
- Blue  out  2  blue component

## Operation
- **Tile RAM:** 1000 x 4 bits, synchronous write and synchronous read.
  - Not cleared by reset; contents are undefined until written.
  - A write with WrAddr >= 1000 is ignored.
  - Read and write to the same address in the same cycle: the read returns the old data (read-first).
- **Stage 1 (registered from the inputs):**
  - col = X[9:4], row = Y[8:4], addr = (row<<5) + (row<<3) + col.
  - visible = (X < 640) && (Y < 400).
  - Pixel-in-tile offsets are X[3:0] and Y[3:0].
  - cursor_hit = CursorEn && col == CursorCol && row == CursorRow && (X[3:0] is 0 or 15, or Y[3:0] is 0 or 15).
  - HSYNC_in and VSYNC_in are registered.
  - When not visible, addr is still computed; its value is don't-care.
- **Stage 2:** RAM read at the stage-1 addr. visible, cursor_hit and the syncs are carried forward.
- **Stage 3 (output registers), with colour index i:**
  - not visible: RGB = 0.
  - cursor_hit and blink = 1: RGB = 111/111/11 (white).
  - otherwise: Red = {i[2],i[2],i[3]}, Green = {i[1],i[1],i[3]}, Blue = {i[0],i[3]}.
- **Blink:**
  - 6-bit frame counter increments by 1 whenever stage-1 registers X==0 && Y==0, and wraps 63 -> 0.
  - blink = frame_cnt[5], so the cursor is shown for 32 frames and hidden for 32.
  - blink is sampled at stage 3.

## Timing
- **Latency:** 3 Pixelclock cycles, from the (X, Y, syncs) presented at edge n to HSYNC/VSYNC/RGB valid after edge n+3.
- **Alignment:** RGB and sync are always on the same cycle; there is no skew between them.
- **Write visibility:** a write at edge n is visible to a stage-1 address that reaches the RAM at edge n+1 or later.
- **Reset:** asynchronous; all pipeline registers, the frame counter and the outputs go to 0 immediately.
  - HSYNC = VSYNC = 0 and RGB = 0 while Reset is high.
  - On the first Pixelclock edge after release, the pipeline refills. The outputs carry valid data 3 edges later.
  - Reset mid-frame produces at most a partial frame and needs no recovery action.
- **Boundaries:**
  - X = 639 is visible; X = 640 is blank.
  - Y = 399 is visible; Y = 400 is blank.
  - Tile 999 is at col 39, row 24.
  - X values above 799 and Y values above 448 are simply treated as blank.

## Test plan
- **Reset:** hold Reset with X/Y sweeping -> HSYNC = VSYNC = 0 and RGB = 0. Release -> the first non-reset outputs appear 3 cycles later.
- **Single tile:**
  - Stimulus: write WrAddr = 41, WrData = 4'b0100, then drive X = 16..31, Y = 16..31.
  - Required response: Red = 110, Green = 000, Blue = 00 for exactly those pixels, 3 cycles delayed.
  - Neighbouring unwritten tiles are ignored; preload the whole map with 0 first.
- **Sync alignment:** toggle HSYNC_in/VSYNC_in with known patterns -> identical patterns on HSYNC/VSYNC, delayed exactly 3 cycles and aligned with RGB.
- **Blanking and out-of-range writes:**
  - Map filled with 15.
  - X = 639 -> white; X = 640 -> 0; Y = 400 -> 0.
  - A write to WrAddr = 1000 leaves every visible pixel unchanged.
- **Cursor blink:**
  - Stimulus: CursorEn = 1, CursorCol = 39, CursorRow = 24, map = 0. Run 64 frames.
  - Frames 32-63: the border pixels of tile 999 (X = 624 or 639, or Y = 384 or 399, inside the tile) are white; its interior pixels stay 0.
  - Frames 0-31: the whole tile stays 0.
- **Read/write collision:** write the address currently being read in the same cycle -> the old colour is output for that pixel, and the new colour appears on the next access.
